// File: rtl/screen_selector_if.sv
// Screen-selector signal bundle: raw keys and the frame flag in, screen select
// and status out. The master side drives the keys and vEnable, the slave is the
// selector.
interface screen_selector_if;
   logic       key_next_n;
   logic       key_prev_n;
   logic       vEnable;
   logic [1:0] screen;
   logic [3:0] screen_en;
   logic       pending;
   logic       switch_pulse;
   logic [7:0] press_cnt;

   modport master (
      output key_next_n, key_prev_n, vEnable,
      input  screen, screen_en, pending, switch_pulse, press_cnt
   );

   modport slave (
      input  key_next_n, key_prev_n, vEnable,
      output screen, screen_en, pending, switch_pulse, press_cnt
   );
endinterface

// File: rtl/screen_selector.sv
// Screen selector: synchronises and debounces the next/prev push-buttons,
// queues the requested change and applies it only when vEnable falls, so the
// visible screen never changes mid-frame.
module screen_selector #(
   parameter int N_SCREENS       = 4,
   parameter int DEBOUNCE_CYCLES = 1080000,
   parameter bit RESET_SCREEN_EN = 1'b0
) (
   input logic               clk,
   input logic               reset,
   screen_selector_if.slave  bus
);

   localparam logic [20:0] DB_LAST  = 21'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]  SCR_LAST = 2'(N_SCREENS - 1);

   typedef enum logic [1:0] {REQ_NONE, REQ_NEXT, REQ_PREV} req_t;

   // Key vectors: bit 0 = next, bit 1 = prev. Levels idle high (released).
   logic [1:0]  key_raw_n;
   logic [1:0]  sync_p0   = 2'b11;
   logic [1:0]  sync_p1   = 2'b11;
   logic [1:0]  db_lvl_p2 = 2'b11;
   logic [20:0] db_cnt_p2 [2] = '{21'd0, 21'd0};
   logic [1:0]  press_p2  = 2'b00;

   logic        ven_d          = 1'b0;
   req_t        req_q          = REQ_NONE;
   logic [1:0]  screen_q       = 2'd0;
   logic [3:0]  screen_en_q    = 4'b0001;
   logic        switch_pulse_q = 1'b0;
   logic [7:0]  press_cnt_q    = 8'd0;

   logic        single_press;
   req_t        press_req;
   req_t        eff_req;
   logic        boundary;
   logic [1:0]  screen_nxt;
   logic [7:0]  cnt_inc;

   // Wrap the screen index one step forward or backward modulo N_SCREENS.
   function automatic logic [1:0] wrap_step(input logic [1:0] cur, input req_t r);
      logic [1:0] res;
      res = cur;
      if (r == REQ_NEXT)
         res = (cur == SCR_LAST) ? 2'd0 : cur + 2'd1;
      else if (r == REQ_PREV)
         res = (cur == 2'd0) ? SCR_LAST : cur - 2'd1;
      return res;
   endfunction

   assign key_raw_n = {bus.key_prev_n, bus.key_next_n};

   // Stage p0/p1: two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 2'b11;
         sync_p1 <= 2'b11;
      end else begin
         sync_p0 <= key_raw_n;
         sync_p1 <= sync_p0;
      end
   end

   // Stage p2: per-key debouncer; a press pulse marks an accepted 1->0 flip.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            db_cnt_p2[k] <= '0;
            db_lvl_p2[k] <= 1'b1;
            press_p2[k]  <= 1'b0;
         end else begin
            press_p2[k] <= 1'b0;
            if (sync_p1[k] == db_lvl_p2[k]) begin
               db_cnt_p2[k] <= '0;
            end else if (db_cnt_p2[k] == DB_LAST) begin
               db_cnt_p2[k] <= '0;
               db_lvl_p2[k] <= sync_p1[k];
               press_p2[k]  <= ~sync_p1[k];
            end else begin
               db_cnt_p2[k] <= db_cnt_p2[k] + 21'd1;
            end
         end
      end
   end

   // Simultaneous presses cancel as a request but both still count.
   assign single_press = press_p2[0] ^ press_p2[1];
   assign press_req    = press_p2[0] ? REQ_NEXT : REQ_PREV;
   assign eff_req      = single_press ? press_req : req_q;
   assign boundary     = ven_d & ~bus.vEnable;
   assign screen_nxt   = wrap_step(screen_q, eff_req);
   assign cnt_inc      = {7'd0, press_p2[0]} + {7'd0, press_p2[1]};

   // Request queue and frame-boundary screen update; screen_en tracks screen.
   always_ff @(posedge clk) begin
      if (reset) begin
         ven_d          <= 1'b0;
         req_q          <= REQ_NONE;
         switch_pulse_q <= 1'b0;
         press_cnt_q    <= 8'd0;
         if (RESET_SCREEN_EN) begin
            screen_q    <= 2'd0;
            screen_en_q <= 4'b0001;
         end
      end else begin
         ven_d          <= bus.vEnable;
         switch_pulse_q <= 1'b0;
         press_cnt_q    <= press_cnt_q + cnt_inc;
         if (boundary) begin
            req_q <= REQ_NONE;
            if (eff_req != REQ_NONE) begin
               screen_q       <= screen_nxt;
               screen_en_q    <= 4'b0001 << screen_nxt;
               switch_pulse_q <= 1'b1;
            end
         end else if (single_press) begin
            req_q <= press_req;
         end
      end
   end

   assign bus.screen       = screen_q;
   assign bus.screen_en    = screen_en_q;
   assign bus.pending      = (req_q != REQ_NONE);
   assign bus.switch_pulse = switch_pulse_q;
   assign bus.press_cnt    = press_cnt_q;

endmodule

// File: tb/tb_screen_selector.sv
// Directed bench for screen_selector: two instances share stimulus, one keeping
// the screen across reset and one forcing it to 0.
module tb_screen_selector;

   logic clk;
   logic reset;
   logic key_next_n;
   logic key_prev_n;
   logic vEnable;

   int checks = 0;
   int errors = 0;
   int pulses0 = 0;
   int exp_cnt = 0;

   screen_selector_if ifc0 ();
   screen_selector_if ifc1 ();

   assign ifc0.key_next_n = key_next_n;
   assign ifc0.key_prev_n = key_prev_n;
   assign ifc0.vEnable    = vEnable;
   assign ifc1.key_next_n = key_next_n;
   assign ifc1.key_prev_n = key_prev_n;
   assign ifc1.vEnable    = vEnable;

   screen_selector #(.N_SCREENS(4), .DEBOUNCE_CYCLES(4), .RESET_SCREEN_EN(1'b0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc0.slave)
   );

   screen_selector #(.N_SCREENS(4), .DEBOUNCE_CYCLES(4), .RESET_SCREEN_EN(1'b1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc1.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count switch pulses seen on the first instance.
   always @(negedge clk) begin
      if (ifc0.switch_pulse === 1'b1) pulses0++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold one or both keys low long enough to be accepted, then release.
   task automatic press(input logic nxt, input logic prv);
      key_next_n = ~nxt;
      key_prev_n = ~prv;
      step(8);
      key_next_n = 1'b1;
      key_prev_n = 1'b1;
      step(8);
   endtask

   // One frame with a next (1) or prev (0) press, then check the new screen.
   task automatic frame_press(input logic is_next, input logic [1:0] exp_scr, input string tag);
      vEnable = 1'b1;
      step(2);
      press(is_next, ~is_next);
      exp_cnt++;
      vEnable = 1'b0;
      step(1);
      chk({tag, "_screen"}, 32'(ifc0.screen), 32'(exp_scr));
      chk({tag, "_en"}, 32'(ifc0.screen_en), 32'(4'b0001 << exp_scr));
      step(3);
      vEnable = 1'b1;
      step(2);
   endtask

   initial begin
      reset      = 1'b1;
      key_next_n = 1'b1;
      key_prev_n = 1'b1;
      vEnable    = 1'b0;
      step(2);
      reset = 1'b0;
      step(1);

      // Reset state
      chk("rst_screen", 32'(ifc0.screen), 32'd0);
      chk("rst_en", 32'(ifc0.screen_en), 32'b0001);
      chk("rst_pending", 32'(ifc0.pending), 32'd0);
      chk("rst_cnt", 32'(ifc0.press_cnt), 32'd0);
      chk("rst_pulse", 32'(ifc0.switch_pulse), 32'd0);

      // Three idle frames: nothing moves
      repeat (3) begin
         vEnable = 1'b1;
         step(10);
         vEnable = 1'b0;
         step(5);
      end
      chk("idle_screen", 32'(ifc0.screen), 32'd0);
      chk("idle_pending", 32'(ifc0.pending), 32'd0);
      chk("idle_pulses", 32'(pulses0), 32'd0);

      // Next held 10 cycles during active video; change waits for boundary
      vEnable = 1'b1;
      step(2);
      key_next_n = 1'b0;
      step(10);
      key_next_n = 1'b1;
      chk("q_pending", 32'(ifc0.pending), 32'd1);
      chk("q_screen_held", 32'(ifc0.screen), 32'd0);
      chk("q_cnt", 32'(ifc0.press_cnt), 32'd1);
      step(8);
      chk("q_screen_still", 32'(ifc0.screen), 32'd0);
      vEnable = 1'b0;
      step(1);
      chk("b_screen", 32'(ifc0.screen), 32'd1);
      chk("b_en", 32'(ifc0.screen_en), 32'b0010);
      chk("b_pulse", 32'(ifc0.switch_pulse), 32'd1);
      chk("b_pending", 32'(ifc0.pending), 32'd0);
      step(1);
      chk("b_pulse_off", 32'(ifc0.switch_pulse), 32'd0);
      chk("b_pulses", 32'(pulses0), 32'd1);
      step(2);
      exp_cnt = 1;

      // Bounce: three 3-cycle lows with 1-cycle highs, then steady low
      vEnable = 1'b1;
      step(2);
      repeat (3) begin
         key_next_n = 1'b0;
         step(3);
         key_next_n = 1'b1;
         step(1);
      end
      chk("bnc_no_press", 32'(ifc0.press_cnt), 32'd1);
      key_next_n = 1'b0;
      step(10);
      key_next_n = 1'b1;
      step(8);
      exp_cnt++;
      chk("bnc_cnt", 32'(ifc0.press_cnt), 32'(exp_cnt));
      chk("bnc_pending", 32'(ifc0.pending), 32'd1);
      vEnable = 1'b0;
      step(1);
      chk("bnc_screen", 32'(ifc0.screen), 32'd2);
      step(3);

      // Walk up to 3, wrap to 0, prev wraps back to 3, then 0,1,2,3
      frame_press(1'b1, 2'd3, "up3");
      frame_press(1'b1, 2'd0, "wrap0");
      frame_press(1'b0, 2'd3, "prev3");
      frame_press(1'b1, 2'd0, "seq0");
      frame_press(1'b1, 2'd1, "seq1");
      frame_press(1'b1, 2'd2, "seq2");
      frame_press(1'b1, 2'd3, "seq3");
      chk("seq_cnt", 32'(ifc0.press_cnt), 32'(exp_cnt));
      chk("seq_twin", 32'(ifc1.screen), 32'd3);

      // Next then prev in one frame: last wins, both counted
      vEnable = 1'b1;
      step(2);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      exp_cnt += 2;
      chk("lw_pending", 32'(ifc0.pending), 32'd1);
      chk("lw_cnt", 32'(ifc0.press_cnt), 32'(exp_cnt));
      vEnable = 1'b0;
      step(1);
      chk("lw_screen", 32'(ifc0.screen), 32'd2);
      step(3);

      // Both keys in the same cycle: counted twice, no request
      vEnable = 1'b1;
      step(2);
      press(1'b1, 1'b1);
      exp_cnt += 2;
      chk("both_cnt", 32'(ifc0.press_cnt), 32'(exp_cnt));
      chk("both_pending", 32'(ifc0.pending), 32'd0);
      vEnable = 1'b0;
      step(1);
      chk("both_screen", 32'(ifc0.screen), 32'd2);
      step(3);
      chk("pulses_total", 32'(pulses0), 32'd10);

      // Reset with a queued request at screen 2
      vEnable = 1'b1;
      step(2);
      press(1'b1, 1'b0);
      chk("pre_rst_pending", 32'(ifc0.pending), 32'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(2);
      chk("mr_pending0", 32'(ifc0.pending), 32'd0);
      chk("mr_cnt0", 32'(ifc0.press_cnt), 32'd0);
      chk("mr_screen0", 32'(ifc0.screen), 32'd2);
      chk("mr_en0", 32'(ifc0.screen_en), 32'b0100);
      chk("mr_pending1", 32'(ifc1.pending), 32'd0);
      chk("mr_screen1", 32'(ifc1.screen), 32'd0);
      chk("mr_en1", 32'(ifc1.screen_en), 32'b0001);
      vEnable = 1'b0;
      step(1);
      chk("mr_b_screen0", 32'(ifc0.screen), 32'd2);
      chk("mr_b_screen1", 32'(ifc1.screen), 32'd0);
      chk("mr_b_pulse", 32'(ifc0.switch_pulse), 32'd0);
      step(3);
      chk("mr_pulses", 32'(pulses0), 32'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
